// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity helper and the
// CLK_DIV legality rules common to the receiver and transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int CLK_DIV_MIN   = 4;
  localparam int MAX_DATA_BITS = 9;

  // The bit period must split into two equal halves for mid-bit sampling.
  function automatic bit clk_div_legal(input int div);
    return (div >= CLK_DIV_MIN) && ((div % 2) == 0);
  endfunction

  // Parity bit a transmitter appends; unused upper bits must be zero.
  function automatic logic uart_parity(input logic [MAX_DATA_BITS-1:0] data,
                                       input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: loads on strobe, otherwise counts down to zero and
// holds there; expired flags the zero count.
module uart_bit_timer #(
  parameter int CLK_DIV = 16
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       load,
  input  logic [$clog2(CLK_DIV)-1:0] load_val,
  output logic                       expired
);

  logic [$clog2(CLK_DIV)-1:0] cnt;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with valid/ready output and error
// sidebands. Define UART_RX_PARITY_EN to receive and check a parity bit.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter int N_BIT_STOP = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rxd_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 frame_err_out,
  output logic                 parity_err_out,
  output logic                 overrun_out
);

  localparam int TW = $clog2(CLK_DIV);
  localparam int IW = 4;
  localparam logic [TW-1:0] HALF_M1 = TW'(CLK_DIV / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLK_DIV - 1);

  if (!clk_div_legal(CLK_DIV)) begin : g_bad_clk_div
    $error("uart_rx_param: CLK_DIV must be even and >= %0d", CLK_DIV_MIN);
  end
  if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS ||
      N_BIT_STOP < 1 || N_BIT_STOP > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_frame
    $error("uart_rx_param: illegal frame format parameters");
  end

  logic rx_meta, rxs, rxs_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= rxd_in;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  logic          tmr_load, tmr_expired;
  logic [TW-1:0] tmr_load_val;

  uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .load    (tmr_load),
    .load_val(tmr_load_val),
    .expired (tmr_expired)
  );

  rx_state_e            state, state_nxt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 ferr_acc;
  logic                 frame_start, shift_en, stop_en, deliver, load_word;
  logic                 last_data, last_stop;
`ifdef UART_RX_PARITY_EN
  logic                 par_en;
`endif

  assign last_data = (bit_idx == IW'(DATA_BITS - 1));
  assign last_stop = (bit_idx == IW'(N_BIT_STOP - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case statement can leave a value held and infer a latch.
  always_comb begin
    state_nxt    = state;
    tmr_load     = 1'b0;
    tmr_load_val = FULL_M1;
    frame_start  = 1'b0;
    shift_en     = 1'b0;
    stop_en      = 1'b0;
    deliver      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en       = 1'b0;
`endif
    case (state)
      IDLE: if (rxs_prev && !rxs) begin
        tmr_load     = 1'b1;
        tmr_load_val = HALF_M1;
        state_nxt    = START;
      end
      START: if (tmr_expired) begin
        if (rxs) begin
          state_nxt = IDLE;
        end else begin
          tmr_load    = 1'b1;
          frame_start = 1'b1;
          state_nxt   = DATA;
        end
      end
      DATA: if (tmr_expired) begin
        tmr_load = 1'b1;
        shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
        if (last_data) state_nxt = PARITY;
`else
        if (last_data) state_nxt = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tmr_expired) begin
        tmr_load  = 1'b1;
        par_en    = 1'b1;
        state_nxt = STOP;
      end
`endif
      STOP: if (tmr_expired) begin
        stop_en = 1'b1;
        if (last_stop) begin
          deliver   = 1'b1;
          state_nxt = IDLE;
        end else begin
          tmr_load = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A finished frame is taken only when the output slot is free or draining.
  assign load_word = deliver && (!valid_out || ready_in);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      shreg         <= '0;
      bit_idx       <= '0;
      ferr_acc      <= 1'b0;
      data_out      <= '0;
      valid_out     <= 1'b0;
      frame_err_out <= 1'b0;
      overrun_out   <= 1'b0;
    end else begin
      overrun_out <= 1'b0;
      if (frame_start) begin
        bit_idx  <= '0;
        ferr_acc <= 1'b0;
      end else if (shift_en) begin
        shreg   <= {rxs, shreg[DATA_BITS-1:1]};
        bit_idx <= last_data ? '0 : bit_idx + 1'b1;
      end else if (stop_en) begin
        bit_idx <= bit_idx + 1'b1;
        if (!rxs) ferr_acc <= 1'b1;
      end
      if (load_word) begin
        data_out      <= shreg;
        valid_out     <= 1'b1;
        frame_err_out <= ferr_acc | ~rxs;
      end else begin
        if (deliver)               overrun_out <= 1'b1;
        if (valid_out && ready_in) valid_out   <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic [MAX_DATA_BITS-1:0] par_data;
  logic                     perr_acc, perr_q;

  always_comb begin
    par_data                = '0;
    par_data[DATA_BITS-1:0] = shreg;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      perr_acc <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      if (frame_start) perr_acc <= 1'b0;
      else if (par_en) perr_acc <= rxs ^ uart_parity(par_data, PARITY_ODD != 0);
      if (load_word)   perr_q   <= perr_acc;
    end
  end

  assign parity_err_out = perr_q;
`else
  assign parity_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: directed frames plus randomized
// traffic, scored against a word-level model of the serial frames sent.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int CLK_DIV    = 16;
  localparam int DATA_BITS  = 8;
  localparam int N_BIT_STOP = 1;
  localparam int PARITY_ODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LAT        = 2 + CLK_DIV / 2 + (DATA_BITS + P + N_BIT_STOP) * CLK_DIV + 1;
  localparam int FRAME_CLKS = (1 + DATA_BITS + P + N_BIT_STOP) * CLK_DIV;

  typedef struct {
    logic [DATA_BITS-1:0] data;
    logic                 ferr;
    logic                 perr;
  } word_t;

  logic                 clk_in = 1'b0;
  logic                 rst_in, rxd_in, ready_in;
  logic [DATA_BITS-1:0] data_out;
  logic                 valid_out, frame_err_out, parity_err_out, overrun_out;

  word_t sb_q[$];
  int    n_cmp = 0, n_bad = 0;
  int    cyc = 0, t_fall = 0, last_rise = 0, ovr_cnt = 0;
  logic  valid_prev = 1'b0;

  uart_rx_param #(
    .CLK_DIV   (CLK_DIV),
    .DATA_BITS (DATA_BITS),
    .N_BIT_STOP(N_BIT_STOP),
    .PARITY_ODD(PARITY_ODD)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rxd_in        (rxd_in),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .frame_err_out (frame_err_out),
    .parity_err_out(parity_err_out),
    .overrun_out   (overrun_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Parity bit a correct transmitter would send for this word.
  function automatic logic good_par(input logic [DATA_BITS-1:0] d);
    return logic'(($countones(d) % 2) == 1) ^ logic'(PARITY_ODD != 0);
  endfunction

  // Word the receiver must report for a frame with these line bits.
  task automatic expect_word(input logic [DATA_BITS-1:0] d, input logic pbit,
                             input logic [1:0] stops);
    word_t w;
    w.data = d;
    w.ferr = 1'b0;
    for (int i = 0; i < N_BIT_STOP; i++) if (!stops[i]) w.ferr = 1'b1;
`ifdef UART_RX_PARITY_EN
    w.perr = (pbit != good_par(d));
`else
    w.perr = 1'b0;
`endif
    sb_q.push_back(w);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic pbit,
                            input logic [1:0] stops);
    t_fall = cyc;
    rxd_in = 1'b0;
    repeat (CLK_DIV) step();
    for (int i = 0; i < DATA_BITS; i++) begin
      rxd_in = d[i];
      repeat (CLK_DIV) step();
    end
`ifdef UART_RX_PARITY_EN
    rxd_in = pbit;
    repeat (CLK_DIV) step();
`endif
    for (int i = 0; i < N_BIT_STOP; i++) begin
      rxd_in = stops[i];
      repeat (CLK_DIV) step();
    end
    rxd_in = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb_q.size() != 0 && n < 4 * FRAME_CLKS) begin
      step();
      n++;
    end
    check(tag, 32'(sb_q.size()), 32'd0);
  endtask

  // Scoreboard: every accepted word must match the oldest expected one.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (overrun_out) ovr_cnt++;
      if (valid_out && !valid_prev) last_rise = cyc;
      if (valid_out && ready_in) begin
        if (sb_q.size() == 0) begin
          check("unexpected_word", 32'(valid_out & ready_in), 32'd0);
        end else begin
          word_t w;
          w = sb_q.pop_front();
          check("word_data", 32'(data_out), 32'(w.data));
          check("word_ferr", 32'(frame_err_out), 32'(w.ferr));
          check("word_perr", 32'(parity_err_out), 32'(w.perr));
        end
      end
    end
    valid_prev = valid_out;
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [DATA_BITS-1:0] d;
    logic [1:0]           stops;
    logic                 pbit, stop_err;
    int                   gap;

    rst_in   = 1'b1;
    rxd_in   = 1'b1;
    ready_in = 1'b1;
    repeat (4) step();
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_ferr", 32'(frame_err_out), 32'd0);
    check("rst_perr", 32'(parity_err_out), 32'd0);
    check("rst_ovr", 32'(overrun_out), 32'd0);
    rst_in = 1'b0;
    repeat (3) step();

    // Nominal frame and end-to-end latency.
    expect_word(8'hA5, good_par(8'hA5), 2'b11);
    send_frame(8'hA5, good_par(8'hA5), 2'b11);
    wait_drain("a5_drain");
    check("a5_latency", 32'(last_rise - t_fall), 32'(LAT));

    // Short glitch must be rejected as a false start.
    rxd_in = 1'b0;
    repeat (4) step();
    rxd_in = 1'b1;
    repeat (2 * CLK_DIV) step();
    check("glitch_valid", 32'(valid_out), 32'd0);
    check("glitch_state", 32'(dut.state), 32'(IDLE));
    expect_word(8'h3C, good_par(8'h3C), 2'b11);
    send_frame(8'h3C, good_par(8'h3C), 2'b11);
    wait_drain("3c_drain");

    // Stop bit low.
    expect_word(8'h81, good_par(8'h81), 2'b00);
    send_frame(8'h81, good_par(8'h81), 2'b00);
    wait_drain("81_drain");
    repeat (CLK_DIV) step();

`ifdef UART_RX_PARITY_EN
    expect_word(8'h07, 1'b0, 2'b11);
    send_frame(8'h07, 1'b0, 2'b11);
    expect_word(8'h07, 1'b1, 2'b11);
    send_frame(8'h07, 1'b1, 2'b11);
    wait_drain("par_drain");
`endif

    // Overrun: second frame dropped while the first is unread.
    ready_in = 1'b0;
    base = ovr_cnt;
    expect_word(8'h11, good_par(8'h11), 2'b11);
    send_frame(8'h11, good_par(8'h11), 2'b11);
    send_frame(8'h22, good_par(8'h22), 2'b11);
    repeat (CLK_DIV) step();
    check("ovr1_count", 32'(ovr_cnt - base), 32'd1);
    check("ovr1_data", 32'(data_out), 32'h11);
    check("ovr1_valid", 32'(valid_out), 32'd1);
    ready_in = 1'b1;
    wait_drain("ovr1_drain");

    // Accept in the completion cycle of the second frame: no drop.
    ready_in = 1'b0;
    base = ovr_cnt;
    expect_word(8'h11, good_par(8'h11), 2'b11);
    expect_word(8'h22, good_par(8'h22), 2'b11);
    send_frame(8'h11, good_par(8'h11), 2'b11);
    fork
      send_frame(8'h22, good_par(8'h22), 2'b11);
      begin
        repeat (LAT - 1) step();
        ready_in = 1'b1;
        step();
        ready_in = 1'b0;
      end
    join
    repeat (CLK_DIV) step();
    check("ovr2_count", 32'(ovr_cnt - base), 32'd0);
    check("ovr2_data", 32'(data_out), 32'h22);
    check("ovr2_valid", 32'(valid_out), 32'd1);
    ready_in = 1'b1;
    wait_drain("ovr2_drain");

    // Reset pulse during data bit 4 discards the frame.
    fork
      send_frame(8'hF5, good_par(8'hF5), 2'b11);
      begin
        repeat (CLK_DIV * 5 + CLK_DIV / 2) step();
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
      end
    join
    repeat (CLK_DIV) step();
    check("midrst_valid", 32'(valid_out), 32'd0);
    check("midrst_data", 32'(data_out), 32'd0);
    expect_word(8'h5A, good_par(8'h5A), 2'b11);
    send_frame(8'h5A, good_par(8'h5A), 2'b11);
    wait_drain("5a_drain");

    // Break: one all-zero word with frame error, then silence.
    expect_word('0, 1'b0, 2'b00);
    rxd_in = 1'b0;
    repeat (FRAME_CLKS + 3 * CLK_DIV) step();
    rxd_in = 1'b1;
    repeat (2 * CLK_DIV) step();
    wait_drain("break_drain");

    // Randomized traffic, including back-to-back frames.
    for (int k = 0; k < 24; k++) begin
      d        = DATA_BITS'($urandom);
      stop_err = ($urandom_range(0, 5) == 0);
      if (!stop_err)            stops = 2'b11;
      else if (N_BIT_STOP == 1) stops = 2'b10;
      else                      stops = 2'($urandom_range(0, 2));
      pbit = good_par(d) ^ ($urandom_range(0, 3) == 0);
      expect_word(d, pbit, stops);
      send_frame(d, pbit, stops);
      gap = $urandom_range(0, 24) + (stop_err ? CLK_DIV : 0);
      repeat (gap) step();
    end
    wait_drain("rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
